// File: rtl/sdram_port_arb.sv
// Two-client arbiter (byte-wide CPU, word-wide loader) onto the SDRAM controller's toggle req/ack port.
// Optional one-entry CPU read cache enabled by defining SDRAM_ARB_RDCACHE_EN.
module sdram_port_arb (
    input  logic        clk,
    input  logic        init_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_a,
    input  logic [7:0]  cpu_d,
    output logic [7:0]  cpu_q,
    output logic        cpu_rdy,
    input  logic        dl_req,
    input  logic [20:0] dl_a,
    input  logic [15:0] dl_d,
    output logic        dl_rdy,
    output logic        sd_req,
    input  logic        sd_ack,
    output logic        sd_we,
    output logic [20:0] sd_a,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_d,
    input  logic [15:0] sd_q
);

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            rr_last_dl, rr_last_dl_nxt;
    logic            own_dl, own_dl_nxt;
    logic            op_rd, op_rd_nxt;
    logic            lo_sel, lo_sel_nxt;
    logic [DW-1:0]   rd_data, rd_data_nxt;
    logic            sd_req_nxt, sd_we_nxt;
    logic [AW-1:0]   sd_a_nxt;
    logic [1:0]      sd_ds_nxt;
    logic [DW-1:0]   sd_d_nxt;
    logic [BW-1:0]   cpu_q_nxt;
    logic            cpu_rdy_nxt, dl_rdy_nxt;
    logic            cpu_pend, dl_pend, cpu_win, cpu_hit;

`ifdef SDRAM_ARB_RDCACHE_EN
    logic [AW-1:0]   c_tag, c_tag_nxt;
    logic            c_vld, c_vld_nxt;
    logic [DW-1:0]   c_data, c_data_nxt;
    logic            c_hit, c_hit_nxt;

    assign cpu_hit = c_vld && !cpu_we && (c_tag == cpu_a[21:1]);
`else
    assign cpu_hit = 1'b0;
`endif

    // The client just served still holds req while its rdy is high; mask it for that cycle.
    assign cpu_pend = cpu_req && !cpu_rdy;
    assign dl_pend  = dl_req && !dl_rdy;
    assign cpu_win  = cpu_pend && (!dl_pend || rr_last_dl);

    always_comb begin
        state_nxt      = state;
        rr_last_dl_nxt = rr_last_dl;
        own_dl_nxt     = own_dl;
        op_rd_nxt      = op_rd;
        lo_sel_nxt     = lo_sel;
        rd_data_nxt    = rd_data;
        sd_req_nxt     = sd_req;
        sd_we_nxt      = sd_we;
        sd_a_nxt       = sd_a;
        sd_ds_nxt      = sd_ds;
        sd_d_nxt       = sd_d;
        cpu_q_nxt      = cpu_q;
        cpu_rdy_nxt    = 1'b0;
        dl_rdy_nxt     = 1'b0;
`ifdef SDRAM_ARB_RDCACHE_EN
        c_tag_nxt      = c_tag;
        c_vld_nxt      = c_vld;
        c_data_nxt     = c_data;
        c_hit_nxt      = c_hit;
`endif
        case (state)
            S_IDLE: begin
                // A req/ack mismatch left over from reset is realigned before anything is issued.
                if (sd_req != sd_ack) begin
                    sd_req_nxt = sd_ack;
                end else if (cpu_win) begin
                    rr_last_dl_nxt = 1'b0;
                    own_dl_nxt     = 1'b0;
                    op_rd_nxt      = !cpu_we;
                    lo_sel_nxt     = cpu_a[0];
`ifdef SDRAM_ARB_RDCACHE_EN
                    c_hit_nxt = cpu_hit;
                    if (cpu_we && (c_tag == cpu_a[21:1]))
                        c_vld_nxt = 1'b0;
                    if (cpu_hit)
                        rd_data_nxt = c_data;
`endif
                    if (cpu_hit) begin
                        state_nxt = S_DONE;
                    end else begin
                        sd_we_nxt  = cpu_we;
                        sd_a_nxt   = cpu_a[21:1];
                        sd_ds_nxt  = cpu_a[0] ? 2'b01 : 2'b10;
                        sd_d_nxt   = {cpu_d, cpu_d};
                        sd_req_nxt = !sd_req;
                        state_nxt  = S_WAIT;
                    end
                end else if (dl_pend) begin
                    rr_last_dl_nxt = 1'b1;
                    own_dl_nxt     = 1'b1;
                    op_rd_nxt      = 1'b0;
                    sd_we_nxt      = 1'b1;
                    sd_a_nxt       = dl_a;
                    sd_ds_nxt      = 2'b11;
                    sd_d_nxt       = dl_d;
                    sd_req_nxt     = !sd_req;
                    state_nxt      = S_WAIT;
`ifdef SDRAM_ARB_RDCACHE_EN
                    c_hit_nxt = 1'b0;
                    if (c_tag == dl_a)
                        c_vld_nxt = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (sd_ack == sd_req) begin
                    rd_data_nxt = sd_q;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                if (own_dl) begin
                    dl_rdy_nxt = 1'b1;
                end else begin
                    cpu_rdy_nxt = 1'b1;
                    if (op_rd) begin
                        cpu_q_nxt = lo_sel ? rd_data[7:0] : rd_data[15:8];
`ifdef SDRAM_ARB_RDCACHE_EN
                        if (!c_hit) begin
                            c_tag_nxt  = sd_a;
                            c_data_nxt = rd_data;
                            c_vld_nxt  = 1'b1;
                        end
`endif
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= S_IDLE;
            rr_last_dl <= 1'b1;
            own_dl     <= 1'b0;
            op_rd      <= 1'b0;
            lo_sel     <= 1'b0;
            rd_data    <= '0;
            sd_req     <= 1'b0;
            sd_we      <= 1'b0;
            sd_a       <= '0;
            sd_ds      <= 2'b00;
            sd_d       <= '0;
            cpu_q      <= '0;
            cpu_rdy    <= 1'b0;
            dl_rdy     <= 1'b0;
`ifdef SDRAM_ARB_RDCACHE_EN
            c_tag      <= '0;
            c_vld      <= 1'b0;
            c_data     <= '0;
            c_hit      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            rr_last_dl <= rr_last_dl_nxt;
            own_dl     <= own_dl_nxt;
            op_rd      <= op_rd_nxt;
            lo_sel     <= lo_sel_nxt;
            rd_data    <= rd_data_nxt;
            sd_req     <= sd_req_nxt;
            sd_we      <= sd_we_nxt;
            sd_a       <= sd_a_nxt;
            sd_ds      <= sd_ds_nxt;
            sd_d       <= sd_d_nxt;
            cpu_q      <= cpu_q_nxt;
            cpu_rdy    <= cpu_rdy_nxt;
            dl_rdy     <= dl_rdy_nxt;
`ifdef SDRAM_ARB_RDCACHE_EN
            c_tag      <= c_tag_nxt;
            c_vld      <= c_vld_nxt;
            c_data     <= c_data_nxt;
            c_hit      <= c_hit_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_port_arb.sv
// Scoreboard bench for sdram_port_arb: byte-level reference memory, toggle-handshake controller model.
module tb_sdram_port_arb;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [21:0] cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    logic [7:0]  cpu_q;
    logic        cpu_rdy;
    logic        dl_req = 1'b0;
    logic [20:0] dl_a = '0;
    logic [15:0] dl_d = '0;
    logic        dl_rdy;
    logic        sd_req;
    logic        sd_ack;
    logic        sd_we;
    logic [20:0] sd_a;
    logic [1:0]  sd_ds;
    logic [15:0] sd_d;
    logic [15:0] sd_q;

    sdram_port_arb dut (
        .clk(clk), .init_n(init_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_rdy(cpu_rdy),
        .dl_req(dl_req), .dl_a(dl_a), .dl_d(dl_d), .dl_rdy(dl_rdy),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_we(sd_we), .sd_a(sd_a),
        .sd_ds(sd_ds), .sd_d(sd_d), .sd_q(sd_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference contents: unwritten words hold a fixed address hash, shared by both memory views.
    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503 + 12345);
    endfunction

    logic [7:0]  refb  [int];
    logic [15:0] sdmem [int];

    function automatic logic [7:0] ref_byte(input logic [21:0] a);
        logic [15:0] w;
        if (refb.exists(int'(a))) return refb[int'(a)];
        w = init_word(int'(a[21:1]));
        return a[0] ? w[7:0] : w[15:8];
    endfunction

    typedef struct { bit rd; logic [7:0] data; } cpu_exp_t;
    cpu_exp_t cpu_exp_q[$];
    bit       dl_exp_q[$];
    bit       rdy_log[$];
    cpu_exp_t mon_e;
    logic [7:0] mon_last_q = '0;
    logic     prev_cpu_rdy = 1'b0, prev_dl_rdy = 1'b0;

    // Monitor: pop an expectation for every rdy pulse the DUT presents.
    always @(negedge clk) begin
        if (init_n) begin
            if (cpu_rdy) begin
                rdy_log.push_back(1'b0);
                check("cpu_rdy_width", 64'(prev_cpu_rdy), 64'd0);
                if (cpu_exp_q.size() == 0) begin
                    check("cpu_rdy_spurious", 64'(cpu_exp_q.size()), 64'd1);
                end else begin
                    mon_e = cpu_exp_q.pop_front();
                    if (mon_e.rd) mon_last_q = mon_e.data;
                    check("cpu_q", 64'(cpu_q), 64'(mon_last_q));
                end
            end
            if (dl_rdy) begin
                rdy_log.push_back(1'b1);
                check("dl_rdy_width", 64'(prev_dl_rdy), 64'd0);
                if (dl_exp_q.size() == 0) check("dl_rdy_spurious", 64'(dl_exp_q.size()), 64'd1);
                else void'(dl_exp_q.pop_front());
            end
        end
        prev_cpu_rdy = cpu_rdy;
        prev_dl_rdy  = dl_rdy;
    end

    // Controller model: a new toggle that mismatches ack is an access; ack after a random delay.
    logic        prev_req = 1'b0;
    logic        snap_req, snap_we, stable;
    logic [20:0] snap_a;
    logic [1:0]  snap_ds;
    logic [15:0] snap_d, mw;
    int          issue_cnt = 0;
    int          ack_cyc = 0;

    initial begin
        sd_ack = 1'b1;
        sd_q   = '0;
        forever begin
            @(posedge clk); #1;
            if (init_n && sd_req != prev_req && sd_req != sd_ack) begin
                snap_req = sd_req; snap_we = sd_we; snap_a = sd_a; snap_ds = sd_ds; snap_d = sd_d;
                issue_cnt++;
                stable = 1'b1;
                repeat ($urandom_range(1, 4)) begin
                    @(posedge clk); #1;
                    if ({sd_req, sd_we, sd_a, sd_ds, sd_d} !== {snap_req, snap_we, snap_a, snap_ds, snap_d})
                        stable = 1'b0;
                end
                check("sd_stable", 64'(stable), 64'd1);
                mw = sdmem.exists(int'(snap_a)) ? sdmem[int'(snap_a)] : init_word(int'(snap_a));
                if (snap_we) begin
                    if (snap_ds[1]) mw[15:8] = snap_d[15:8];
                    if (snap_ds[0]) mw[7:0]  = snap_d[7:0];
                    sdmem[int'(snap_a)] = mw;
                    sd_q = 16'($urandom);
                end else begin
                    sd_q = mw;
                end
                sd_ack  = ~sd_ack;
                ack_cyc = cyc;
            end
            prev_req = sd_req;
        end
    end

    task automatic cpu_access(input bit we, input logic [21:0] a, input logic [7:0] d,
                              output int t_req, output int t_rdy);
        cpu_exp_t e;
        bit got;
        e.rd = !we;
        e.data = we ? 8'h00 : ref_byte(a);
        if (we) refb[int'(a)] = d;
        cpu_exp_q.push_back(e);
        @(negedge clk);
        cpu_we = we; cpu_a = a; cpu_d = d; cpu_req = 1'b1;
        t_req = cyc;
        got = 1'b0;
        t_rdy = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cpu_rdy) begin got = 1'b1; t_rdy = cyc; break; end
        end
        if (!got) check("cpu_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dl_access(input logic [20:0] a, input logic [15:0] d);
        bit got;
        refb[int'({a, 1'b0})] = d[15:8];
        refb[int'({a, 1'b1})] = d[7:0];
        dl_exp_q.push_back(1'b1);
        @(negedge clk);
        dl_a = a; dl_d = d; dl_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dl_rdy) begin got = 1'b1; break; end
        end
        if (!got) check("dl_timeout", 64'(got), 64'd1);
        @(posedge clk); #1;
        dl_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        init_n = 1'b0;
        repeat (3) @(negedge clk);
        mon_last_q = '0;
        init_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    int tq, tr, base;
    logic [15:0] w;

    initial begin
        // Reset values, then realignment of sd_req to an ack left high.
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({sd_req, sd_we, sd_a, sd_ds, sd_d, cpu_q, cpu_rdy, dl_rdy}), 64'd0);
        init_n = 1'b1;
        @(negedge clk);
        check("realign_sd_req", 64'(sd_req), 64'd1);
        repeat (5) @(negedge clk);
        check("no_issue_after_reset", 64'(issue_cnt), 64'd0);

        // CPU byte write to the low lane.
        cpu_access(1'b1, 22'h000101, 8'hA5, tq, tr);
        check("wr_sd_a", 64'(snap_a), 64'h80);
        check("wr_sd_ds", 64'(snap_ds), 64'h1);
        check("wr_sd_d", 64'(snap_d), 64'hA5A5);
        check("wr_sd_we", 64'(snap_we), 64'd1);
        check("wr_latency", 64'(tr - ack_cyc), 64'd2);

        // Big-endian read steering.
        dl_access(21'h000080, 16'h1234);
        cpu_access(1'b0, 22'h000100, 8'h00, tq, tr);
        check("rd_sd_ds", 64'(snap_ds), 64'h2);
        check("rd_hi_q", 64'(cpu_q), 64'h12);
        cpu_access(1'b0, 22'h000101, 8'h00, tq, tr);
        check("rd_lo_q", 64'(cpu_q), 64'h34);

        // Simultaneous requests after reset: CPU first, then DL; then DL wins after a CPU grant.
        do_reset();
        repeat (2) @(negedge clk);
        rdy_log.delete();
        fork
            cpu_access(1'b0, 22'h000100, 8'h00, tq, tr);
            dl_access(21'h000300, 16'h5555);
        join
        check("rr1_count", 64'(rdy_log.size()), 64'd2);
        if (rdy_log.size() == 2) begin
            check("rr1_first_cpu", 64'(rdy_log[0]), 64'd0);
            check("rr1_second_dl", 64'(rdy_log[1]), 64'd1);
        end
        cpu_access(1'b1, 22'h000010, 8'h3C, tq, tr);
        rdy_log.delete();
        fork
            begin int a1, a2; cpu_access(1'b0, 22'h000010, 8'h00, a1, a2); end
            dl_access(21'h000301, 16'hAAAA);
        join
        check("rr2_count", 64'(rdy_log.size()), 64'd2);
        if (rdy_log.size() == 2) begin
            check("rr2_first_dl", 64'(rdy_log[0]), 64'd1);
            check("rr2_second_cpu", 64'(rdy_log[1]), 64'd0);
        end

        // Loader write at the top word address.
        dl_access(21'h1FFFFF, 16'hBEEF);
        check("dl_sd_ds", 64'(snap_ds), 64'h3);
        check("dl_sd_d", 64'(snap_d), 64'hBEEF);
        check("dl_sd_a", 64'(snap_a), 64'h1FFFFF);
        check("dl_sd_we", 64'(snap_we), 64'd1);
        cpu_access(1'b0, 22'h3FFFFE, 8'h00, tq, tr);
        cpu_access(1'b0, 22'h3FFFFF, 8'h00, tq, tr);

        // Repeated read of one word, then loader overwrite and re-read.
        base = issue_cnt;
        cpu_access(1'b0, 22'h000200, 8'h00, tq, tr);
        cpu_access(1'b0, 22'h000200, 8'h00, tq, tr);
`ifdef SDRAM_ARB_RDCACHE_EN
        check("cache_issue_count", 64'(issue_cnt - base), 64'd1);
        check("cache_hit_latency", 64'(tr - tq), 64'd2);
`else
        check("nocache_issue_count", 64'(issue_cnt - base), 64'd2);
`endif
        w = 16'($urandom);
        base = issue_cnt;
        dl_access(21'h000100, w);
        cpu_access(1'b0, 22'h000200, 8'h00, tq, tr);
        check("inval_issue_count", 64'(issue_cnt - base), 64'd2);
        check("inval_q", 64'(cpu_q), 64'(w[15:8]));
        cpu_access(1'b1, 22'h000201, 8'h77, tq, tr);
        cpu_access(1'b0, 22'h000201, 8'h00, tq, tr);

        // Concurrent random traffic in disjoint regions, then read back the loader region.
        fork
            begin
                int c1, c2;
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    cpu_access(1'($urandom_range(0, 1)), 22'($urandom_range(0, 63)), 8'($urandom), c1, c2);
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    dl_access(21'($urandom_range(32, 63)), 16'($urandom));
                end
            end
        join
        for (int k = 64; k < 128; k += 5)
            cpu_access(1'b0, 22'(k), 8'h00, tq, tr);

        repeat (5) @(negedge clk);
        check("cpu_exp_drained", 64'(cpu_exp_q.size()), 64'd0);
        check("dl_exp_drained", 64'(dl_exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
